// File: rtl/hdlc_rx_deframer_if.sv
// hdlc_rx_deframer_if: received byte stream from the HDLC deframer
interface hdlc_rx_deframer_if;
  logic [7:0] M_Data;
  logic       M_Valid;
  logic       M_Last;
  logic       M_Err;
  modport master(output M_Data, M_Valid, M_Last, M_Err);
  modport slave(input M_Data, M_Valid, M_Last, M_Err);
endinterface

// File: rtl/hdlc_rx_deframer.sv
// hdlc_rx_deframer: flag hunt, stuffed-zero drop and LSB-first octet assembly behind zero-delete
module hdlc_rx_deframer #(
  parameter int MAX_LEN = 2048
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               En,
  input  logic               SRX,
  input  logic               ZdValid,
  hdlc_rx_deframer_if.master m,
  output logic               Active
);
  localparam int CW = $clog2(MAX_LEN);
  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] OPEN = 1'b1;
  logic [0:0]    state;
  logic          en_d, srx_d, pend_v;
  logic [6:0]    raw_sr, byte_sr;
  logic [7:0]    raw_nx, byte_nx, pend;
  logic [2:0]    ones, bit_cnt;
  logic [CW-1:0] cnt;
  logic          open, flag_det, abort_det, fl, ab, bd, overrun, emit, last, err;
  // Shift registers keep only the 7 bits that survive the next shift
  assign raw_nx    = {srx_d, raw_sr};
  assign byte_nx   = {srx_d, byte_sr};
  assign open      = state == OPEN;
  assign flag_det  = en_d && raw_nx == 8'h7E;
  assign abort_det = en_d && srx_d && ones == 3'd6;
  assign fl        = open && flag_det;
  assign ab        = open && !flag_det && abort_det;
  assign bd        = open && !flag_det && !abort_det && en_d && ZdValid && bit_cnt == 3'd7;
  assign overrun   = bd && pend_v && cnt == CW'(MAX_LEN - 1);
  assign emit      = pend_v && (fl || ab || bd);
  assign last      = fl || ab || overrun;
  assign err       = ab || overrun || (fl && bit_cnt != 3'd7);
  assign Active    = open;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= HUNT;
      en_d      <= 1'b0;
      srx_d     <= 1'b0;
      raw_sr    <= '0;
      byte_sr   <= '0;
      ones      <= '0;
      bit_cnt   <= '0;
      pend      <= '0;
      pend_v    <= 1'b0;
      cnt       <= '0;
      m.M_Data  <= '0;
      m.M_Valid <= 1'b0;
      m.M_Last  <= 1'b0;
      m.M_Err   <= 1'b0;
    end else begin
      en_d      <= En;
      srx_d     <= SRX;
      m.M_Valid <= emit;
      m.M_Last  <= emit && last;
      m.M_Err   <= emit && err;
      if (emit) m.M_Data <= pend;
      if (en_d) begin
        raw_sr <= raw_nx[7:1];
        ones   <= !srx_d ? 3'd0 : ones == 3'd7 ? 3'd7 : ones + 3'd1;
      end
      // A flag (re)opens from either state; the pending byte has already been chosen for emission above
      if (flag_det) begin
        state   <= OPEN;
        bit_cnt <= '0;
        pend_v  <= 1'b0;
        cnt     <= '0;
      end else if (ab || overrun) begin
        state  <= HUNT;
        pend_v <= 1'b0;
      end else if (open && en_d && ZdValid) begin
        byte_sr <= byte_nx[7:1];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          pend   <= byte_nx;
          pend_v <= 1'b1;
          if (pend_v) cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// tb_hdlc_rx_deframer: directed byte/flag vectors through a behavioural zero-delete model
module tb_hdlc_rx_deframer;
  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       e;
  } em_t;
  typedef struct {
    logic [7:0] b;
    int         n;
    bit         raw;
    int         en;
    em_t        e0;
    em_t        e1;
    logic       act;
  } vec_t;
  logic Clk = 1'b0, Rst = 1'b1, En = 1'b0, SRX = 1'b0, ZdValid = 1'b1;
  logic Active;
  int   errors = 0, checks = 0;
  int   tx_ones = 0, zd_ones = 0;
  em_t  q[$];
  logic prev_v = 1'b0;
  vec_t tv[$];
  hdlc_rx_deframer_if bus();
  hdlc_rx_deframer #(.MAX_LEN(4)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .SRX(SRX), .ZdValid(ZdValid), .m(bus), .Active(Active)
  );
  always #5 Clk = ~Clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  always @(negedge Clk) begin
    if (bus.M_Valid) q.push_back({bus.M_Data, bus.M_Last, bus.M_Err});
    if (!bus.M_Valid && (bus.M_Last || bus.M_Err)) begin
      errors++;
      $display("FAIL idle_flags: got last=%b err=%b expected 0 0", bus.M_Last, bus.M_Err);
    end
    if (bus.M_Valid && prev_v) begin
      errors++;
      $display("FAIL pulse_width: got 2-cycle M_Valid expected 1-cycle");
    end
    prev_v = bus.M_Valid;
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask
  // Zero-delete model: a 0 after exactly five raw ones is stuffed
  task automatic send_bit(input logic b);
    logic v;
    v = !(b == 1'b0 && zd_ones == 5);
    zd_ones = b ? (zd_ones == 7 ? 7 : zd_ones + 1) : 0;
    @(negedge Clk); En = 1'b1; SRX = b;
    @(negedge Clk); En = 1'b0; ZdValid = v;
    @(negedge Clk);
    @(negedge Clk);
  endtask
  task automatic send(input logic b, input bit raw);
    send_bit(b);
    tx_ones = b ? tx_ones + 1 : 0;
    if (!raw && tx_ones == 5) begin
      send_bit(1'b0);
      tx_ones = 0;
    end
  endtask
  function automatic vec_t mk(input logic [7:0] b, input int n, input bit raw, input int en,
                              input em_t e0, input em_t e1, input logic act);
    vec_t v;
    v.b = b; v.n = n; v.raw = raw; v.en = en; v.e0 = e0; v.e1 = e1; v.act = act;
    return v;
  endfunction
  task automatic apply(input vec_t v, input int idx);
    q.delete();
    for (int i = 0; i < v.n; i++) send(v.b[i], v.raw);
    chk($sformatf("vec%0d.count", idx), q.size(), v.en);
    if (q.size() == v.en) begin
      if (v.en > 0) chk($sformatf("vec%0d.out0", idx), {22'd0, q[0]}, {22'd0, v.e0});
      if (v.en > 1) chk($sformatf("vec%0d.out1", idx), {22'd0, q[1]}, {22'd0, v.e1});
    end
    chk($sformatf("vec%0d.active", idx), Active, v.act);
  endtask
  initial begin
    em_t z;
    z = '0;
    tv.push_back(mk(8'h7E, 8, 1, 0, z, z, 1));
    tv.push_back(mk(8'h55, 8, 0, 0, z, z, 1));
    tv.push_back(mk(8'hAA, 8, 0, 1, {8'h55, 1'b0, 1'b0}, z, 1));
    tv.push_back(mk(8'h7E, 8, 1, 1, {8'hAA, 1'b1, 1'b0}, z, 1));
    tv.push_back(mk(8'h7E, 8, 1, 0, z, z, 1));
    tv.push_back(mk(8'hFF, 8, 0, 0, z, z, 1));
    tv.push_back(mk(8'h7E, 8, 1, 1, {8'hFF, 1'b1, 1'b0}, z, 1));
    tv.push_back(mk(8'h12, 8, 0, 0, z, z, 1));
    tv.push_back(mk(8'h34, 8, 0, 1, {8'h12, 1'b0, 1'b0}, z, 1));
    tv.push_back(mk(8'h7F, 7, 1, 1, {8'h34, 1'b1, 1'b1}, z, 0));
    tv.push_back(mk(8'h34, 8, 0, 0, z, z, 0));
    tv.push_back(mk(8'h7E, 8, 1, 0, z, z, 1));
    tv.push_back(mk(8'h12, 8, 0, 0, z, z, 1));
    tv.push_back(mk(8'h05, 3, 0, 0, z, z, 1));
    tv.push_back(mk(8'h7E, 8, 1, 2, {8'h12, 1'b0, 1'b0}, {8'hF5, 1'b1, 1'b1}, 1));
    tv.push_back(mk(8'h7E, 8, 1, 0, z, z, 1));
    tv.push_back(mk(8'h7E, 8, 1, 0, z, z, 1));
    tv.push_back(mk(8'h01, 8, 0, 0, z, z, 1));
    tv.push_back(mk(8'h02, 8, 0, 1, {8'h01, 1'b0, 1'b0}, z, 1));
    tv.push_back(mk(8'h03, 8, 0, 1, {8'h02, 1'b0, 1'b0}, z, 1));
    tv.push_back(mk(8'h04, 8, 0, 1, {8'h03, 1'b0, 1'b0}, z, 1));
    tv.push_back(mk(8'h05, 8, 0, 1, {8'h04, 1'b1, 1'b1}, z, 0));
    tv.push_back(mk(8'h06, 8, 0, 0, z, z, 0));
    tv.push_back(mk(8'h7E, 8, 1, 0, z, z, 1));
    tv.push_back(mk(8'h12, 8, 0, 0, z, z, 1));
    tv.push_back(mk(8'h34, 8, 0, 1, {8'h12, 1'b0, 1'b0}, z, 1));
    repeat (3) @(negedge Clk);
    chk("reset_outputs", {20'd0, bus.M_Data, bus.M_Valid, bus.M_Last, bus.M_Err, Active}, 32'd0);
    Rst = 1'b0;
    for (int i = 0; i < tv.size(); i++) apply(tv[i], i);
    // Reset mid-bit while 0x34 is still pending: must vanish without any emission
    q.delete();
    @(negedge Clk); En = 1'b1; SRX = 1'b0;
    #2 Rst = 1'b1;
    #1 chk("rst_async", {20'd0, bus.M_Data, bus.M_Valid, bus.M_Last, bus.M_Err, Active}, 32'd0);
    @(negedge Clk); Rst = 1'b0; En = 1'b0; ZdValid = 1'b1;
    tx_ones = 0; zd_ones = 0;
    repeat (6) @(negedge Clk);
    chk("rst_no_emit", q.size(), 0);
    apply(mk(8'h7E, 8, 1, 0, z, z, 1), 100);
    apply(mk(8'h56, 8, 0, 0, z, z, 1), 101);
    apply(mk(8'h7E, 8, 1, 1, {8'h56, 1'b1, 1'b0}, z, 1), 102);
    repeat (4) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
